// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: CPU stores to TXDATA_ADDR queue bytes, STAT_ADDR reads status / clears overflow.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_mmio_tx #(
  parameter logic [11:0] TXDATA_ADDR  = 12'hFF0,
  parameter logic [11:0] STAT_ADDR    = 12'hFF1,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemoryWrite,
  input  logic [11:0] DataAdder,
  input  logic [11:0] WriteData,
  output logic [11:0] ReadData,
  output logic        tx,
  output logic        busy
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [11:0] BIT_LAST = 12'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t             state_q;
  logic [11:0]        bit_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               tx_q;
  logic               busy_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               fifo_empty, fifo_full, bit_end;
  logic               push_req, push, pop, stat_wr, ovf_evt;
  logic [7:0]         pop_data;
  logic               unused_wdata;

  assign unused_wdata = ^WriteData[11:8];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign bit_end    = (bit_cnt_q == BIT_LAST);
  assign pop_data   = mem_q[rd_ptr_q];

  // A pop frees a slot on the same edge, so a push into a full FIFO is still accepted then.
  assign pop      = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign push_req = MemoryWrite && (DataAdder == TXDATA_ADDR);
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_evt  = push_req && !push;
  assign stat_wr  = MemoryWrite && (DataAdder == STAT_ADDR);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ovf_evt)      ovf_d = 1'b1;
    else if (stat_wr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds no state that matters after reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q   <= S_START;
            shift_q   <= pop_data;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + 12'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= S_PARITY;
              tx_q      <= ^shift_q;
`else
              state_q   <= S_STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 12'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q   <= S_STOP;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 12'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            // Chain straight into the next frame when more data is waiting.
            if (pop) begin
              state_q <= S_START;
              shift_q <= pop_data;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 12'd1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bit_cnt_q <= '0;
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign ReadData = (DataAdder == STAT_ADDR) ? {8'b0, ovf_q, fifo_empty, fifo_full, busy_q} : 12'h000;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Bench for uart_mmio_tx: a queue-based line model checked every cycle, plus directed frames with literal expectations.
module tb_uart_mmio_tx;

  localparam int          C     = 4;
  localparam int          DEPTH = 4;
  localparam logic [11:0] TXA   = 12'hFF0;
  localparam logic [11:0] STA   = 12'hFF1;
`ifdef UART_TX_PARITY_EN
  localparam int          NB    = 11;
  localparam bit          PAR   = 1'b1;
`else
  localparam int          NB    = 10;
  localparam bit          PAR   = 1'b0;
`endif
  localparam int          FL    = NB * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemoryWrite = 1'b0;
  logic [11:0] DataAdder = STA;
  logic [11:0] WriteData = 12'h000;
  logic [11:0] ReadData;
  logic        tx;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_mmio_tx #(
    .TXDATA_ADDR(TXA), .STAT_ADDR(STA), .CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .MemoryWrite(MemoryWrite), .DataAdder(DataAdder),
    .WriteData(WriteData), .ReadData(ReadData), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Model: byte queue for the FIFO and a queue of future line samples for the serializer.
  logic [7:0] mq [$];
  bit         line [$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_fb;
  bit         m_v, m_evt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      line.delete();
      m_ovf = 1'b0;
    end else begin
      if (line.size() > 0) void'(line.pop_front());
      if (line.size() == 0 && mq.size() > 0) begin
        m_fb = mq.pop_front();
        for (int k = 0; k < NB; k++) begin
          if (k == 0)                m_v = 1'b0;
          else if (k <= 8)           m_v = m_fb[k-1];
          else if (PAR && k == 9)    m_v = ^m_fb;
          else                       m_v = 1'b1;
          for (int r = 0; r < C; r++) line.push_back(m_v);
        end
      end
      m_evt = 1'b0;
      if (MemoryWrite && DataAdder == TXA) begin
        if (mq.size() < DEPTH) mq.push_back(WriteData[7:0]);
        else m_evt = 1'b1;
      end
      if (m_evt) m_ovf = 1'b1;
      else if (MemoryWrite && DataAdder == STA) m_ovf = 1'b0;
    end
  end

  bit          e_tx, e_busy;
  logic [11:0] e_rd;
  always @(negedge clk) begin
    e_busy = (line.size() != 0);
    e_tx   = e_busy ? line[0] : 1'b1;
    e_rd   = (DataAdder == STA) ?
             {8'b0, m_ovf, (mq.size() == 0), (mq.size() == DEPTH), e_busy} : 12'h000;
    chk("cyc_tx", tx, e_tx);
    chk("cyc_busy", busy, e_busy);
    chk("cyc_readdata", ReadData, e_rd);
  end

  task automatic wr(input logic [11:0] a, input logic [11:0] d);
    @(posedge clk); #1;
    MemoryWrite = 1'b1; DataAdder = a; WriteData = d;
    @(posedge clk); #1;
    MemoryWrite = 1'b0; DataAdder = STA;
    $display("txn write addr=%h data=%h", a, d);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic run_frame(input logic [11:0] d, output logic [7:0] got, output int nbusy,
                           output logic par, output logic st, output logic stp);
    bit s [FL+8];
    wr(TXA, d);
    @(posedge clk);
    nbusy = 0;
    for (int j = 0; j < FL + 8; j++) begin
      @(negedge clk);
      s[j] = tx;
      if (busy) nbusy++;
    end
    st = s[C/2];
    for (int i = 0; i < 8; i++) got[i] = s[(1+i)*C + C/2];
    par = s[9*C + C/2];
    stp = s[(NB-1)*C + C/2];
    $display("txn frame data=%h decoded=%h busy_cycles=%0d", d, got, nbusy);
  endtask

  logic [7:0] got;
  int         nb;
  logic       par, st, stp;

  initial begin
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_stat", ReadData, 12'h004);
    chk("reset_tx", tx, 1'b1);

    run_frame(12'h0A5, got, nb, par, st, stp);
    chk("a5_start", st, 1'b0);
    chk("a5_byte", got, 8'hA5);
    chk("a5_stop", stp, 1'b1);
    chk("a5_busy", nb, FL);

    run_frame(12'hF3C, got, nb, par, st, stp);
    chk("f3c_byte", got, 8'h3C);

`ifdef UART_TX_PARITY_EN
    run_frame(12'h007, got, nb, par, st, stp);
    chk("p07_byte", got, 8'h07);
    chk("p07_parity", par, 1'b1);
    chk("p07_busy", nb, 44);
`endif

    // Push into a full FIFO exactly on the edge that pops it: must be accepted, no overflow.
    @(posedge clk); #1;
    for (int r = 0; r <= FL + 1; r++) begin
      MemoryWrite = (r <= 4 || r == FL + 1);
      DataAdder   = MemoryWrite ? TXA : STA;
      WriteData   = 12'h010 + 12'(r);
      @(posedge clk); #1;
    end
    MemoryWrite = 1'b0; DataAdder = STA;
    @(negedge clk);
    chk("full_pop_push_stat", ReadData, 12'h003);
    $display("txn full-fifo push coinciding with pop");
    wait_idle();

    // Six back-to-back stores: five contiguous frames, sixth dropped.
    @(posedge clk); #1;
    for (int r = 0; r < 6; r++) begin
      MemoryWrite = 1'b1; DataAdder = TXA; WriteData = 12'h0C0 + 12'(r);
      @(posedge clk); #1;
    end
    MemoryWrite = 1'b0; DataAdder = STA;
    @(negedge clk);
    chk("burst_stat", ReadData, 12'h00B);
    nb = 0;
    while (busy && nb < 2000) begin
      nb++;
      @(negedge clk);
    end
    chk("burst_busy_run", nb, 5*FL - 4);
    $display("txn burst of six stores, contiguous busy tail=%0d", nb);
    chk("burst_idle_stat", ReadData, 12'h00C);
    wr(STA, 12'hABC);
    @(negedge clk);
    chk("ovf_cleared", ReadData, 12'h004);

    // Reset in the middle of the data bits with bytes still queued.
    wr(TXA, 12'h05A);
    wr(TXA, 12'h011);
    wr(TXA, 12'h022);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_stat", ReadData, 12'h004);
    $display("txn reset asserted mid-frame");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_stat", ReadData, 12'h004);

    run_frame(12'h081, got, nb, par, st, stp);
    chk("post_rst_byte", got, 8'h81);
    chk("post_rst_busy_len", nb, FL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_mmio_tx.md
UART_MMIO_TX -- requirements
Module: uart_mmio_tx

Interface
REQ-001 Parameter TXDATA_ADDR, default 12'hFF0, meaning: data-memory address whose store enqueues one byte.
REQ-002 Parameter STAT_ADDR, default 12'hFF1, meaning: status register address; read returns status, write clears overflow.
REQ-003 Parameter CLKS_PER_BIT, default 16, meaning: clk cycles per serial bit, legal range 2..4095.
REQ-004 Parameter FIFO_DEPTH, default 4, meaning: transmit FIFO entries, power of two, minimum 2.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port MemoryWrite, input, 1 bit: store strobe from CPU data port.
REQ-008 Port DataAdder, input, 12 bits: CPU data address.
REQ-009 Port WriteData, input, 12 bits: CPU store data.
REQ-010 Port ReadData, output, 12 bits: status readback, combinational.
REQ-011 Port tx, output, 1 bit: serial line, idle high.
REQ-012 Port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-013 Push: MemoryWrite=1 and DataAdder==TXDATA_ADDR at a rising edge SHALL enqueue WriteData[7:0]; WriteData[11:8] ignored.
REQ-014 Push while FIFO full SHALL drop the byte and set sticky ovf; a push coinciding with a pop on a full FIFO SHALL be accepted.
REQ-015 MemoryWrite=1 with DataAdder==STAT_ADDR SHALL clear ovf at that edge; data value ignored; a simultaneous overflow event has priority (ovf stays 1).
REQ-016 ReadData SHALL be {8'b0, ovf, empty, full, busy} (bit3..bit0) when DataAdder==STAT_ADDR, else 12'h000.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-018 FSM states IDLE, START, DATA, PARITY (macro only), STOP; tx=1 in IDLE and STOP, 0 in START, current data bit in DATA.
REQ-019 IDLE with FIFO non-empty SHALL pop at the next edge and enter START; a byte pushed at edge E drives tx low from edge E+1.
REQ-020 Each bit SHALL last exactly CLKS_PER_BIT cycles via a bit-period counter reset on every state/bit change.
REQ-021 DATA SHALL send 8 bits LSB first using a 3-bit index; after bit 7 go to PARITY (macro) or STOP.
REQ-022 At end of STOP: FIFO non-empty -> pop and enter START on the same edge (no idle gap); empty -> IDLE.
REQ-023 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).

Reset
REQ-024 reset low SHALL immediately force state IDLE, tx=1, busy=0, FIFO empty, ovf=0, all counters 0, ReadData per REQ-016.
REQ-025 Reset mid-frame SHALL abort the frame and discard FIFO contents; operation resumes on the first edge after reset deasserts.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY state inserted after DATA, transmitting even parity (XOR of 8 data bits) for one bit period.
REQ-027 Macro undefined: no PARITY state or logic; frame is start, 8 data, stop.

Verification
REQ-028 CLKS_PER_BIT=4, write 12'h0A5 to 12'hFF0 -> tx 0(4 clk), bits 1,0,1,0,0,1,0,1 (4 clk each), 1(4 clk); busy high 40 cycles.
REQ-029 Write 12'hF3C -> byte 8'h3C transmitted; upper nibble absent.
REQ-030 Six back-to-back writes, FIFO_DEPTH=4 -> first five frames contiguous with no idle gap, sixth dropped; STAT read 12'h00B.
REQ-031 After REQ-030, write any value to 12'hFF1 -> STAT bit3=0 on next read.
REQ-032 Assert reset mid-DATA -> tx=1 and busy=0 without a clock edge; STAT read 12'h004.
REQ-033 UART_TX_PARITY_EN defined, write 12'h007 -> parity bit 1 follows data, frame 44 cycles at CLKS_PER_BIT=4.
